// File: rtl/addsub_seq_pkg.sv
// rtl/addsub_seq_pkg.sv - shared types and constants for the byte-serial add/sub sequencer
package addsub_seq_pkg;

    localparam int BYTE_W     = 8;
    localparam int MAX_NBYTES = 16;
    localparam int MAX_W      = BYTE_W * MAX_NBYTES;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    // Sized for the widest legal operand; the top uses the low 8*NBYTES bits.
    typedef struct packed {
        logic [MAX_W-1:0] a;
        logic [MAX_W-1:0] b;
        logic             sub;
    } req_t;

endpackage

// File: rtl/addsub_seq_byte_addsub.sv
// rtl/addsub_seq_byte_addsub.sv - combinational 8-bit add/subtract slice
//
// Computes sum = a + (b ^ {8{sub}}) + cin.
// Ports:
//   a, b  : byte operands
//   sub   : invert b (subtract)
//   cin   : carry in (first byte gets sub, later bytes get the propagated carry)
//   sum   : byte result
//   cout  : carry out
module byte_addsub
    import addsub_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              sub,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W:0] total;

    assign total = {1'b0, a} + {1'b0, b ^ {BYTE_W{sub}}} + {{BYTE_W{1'b0}}, cin};
    assign sum   = total[BYTE_W-1:0];
    assign cout  = total[BYTE_W];

endmodule

// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - round-robin byte-serial 8*NBYTES-bit add/subtract sequencer
//
// Two requesters share one byte slice; an accepted operation runs NBYTES
// EXEC cycles (LSB first) and then presents its result in DONE.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   reqN_valid/ready/a/b/sub      : request port N (ready only in IDLE)
//   rsp_valid/ready/id/sum/cout   : response port, held stable under backpressure
//   rsp_ovf                       : signed overflow, 0 unless ADDSUB_SEQ_OVF_EN
//   busy                          : high in EXEC or DONE
// Optional feature macro: ADDSUB_SEQ_OVF_EN (signed overflow detection).
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [BYTE_W*NBYTES-1:0] req0_a,
    input  logic [BYTE_W*NBYTES-1:0] req0_b,
    input  logic                   req0_sub,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [BYTE_W*NBYTES-1:0] req1_a,
    input  logic [BYTE_W*NBYTES-1:0] req1_b,
    input  logic                   req1_sub,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [BYTE_W*NBYTES-1:0] rsp_sum,
    output logic                   rsp_cout,
    output logic                   rsp_ovf,
    output logic                   busy
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = $clog2(NBYTES);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            sub_q, sub_d;
    logic            id_q, id_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            last_q, last_d;

    logic            grant0, grant1;
    req_t            sel;
    logic [BYTE_W-1:0] a_byte, b_byte, s_byte;
    logic            s_cout;
    logic            last_byte;

    assign a_byte    = a_q[BYTE_W*idx_q +: BYTE_W];
    assign b_byte    = b_q[BYTE_W*idx_q +: BYTE_W];
    assign last_byte = (idx_q == IW'(NBYTES - 1));

    byte_addsub u_slice (
        .a    (a_byte),
        .b    (b_byte),
        .sub  (sub_q),
        .cin  (carry_q),
        .sum  (s_byte),
        .cout (s_cout)
    );

    // With both valid, last_q selects who waits: last_q=1 means 1 was served last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_q);
            grant1 = req1_valid && (!req0_valid || !last_q);
        end
    end

    always_comb begin
        sel     = '0;
        sel.a   = grant1 ? MAX_W'(req1_a) : MAX_W'(req0_a);
        sel.b   = grant1 ? MAX_W'(req1_b) : MAX_W'(req0_b);
        sel.sub = grant1 ? req1_sub : req0_sub;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        id_d    = id_q;
        sum_d   = sum_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    a_d     = sel.a[W-1:0];
                    b_d     = sel.b[W-1:0];
                    sub_d   = sel.sub;
                    id_d    = grant1;
                    last_d  = grant1;
                    idx_d   = '0;
                    carry_d = sel.sub;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                sum_d[BYTE_W*idx_q +: BYTE_W] = s_byte;
                carry_d = s_cout;
                idx_d   = idx_q + 1'b1;
                if (last_byte) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            id_q    <= 1'b0;
            sum_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
        end
    end

`ifdef ADDSUB_SEQ_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: operands of equal sign (after B inversion) give a
    // result of the opposite sign; only the top byte carries the sign.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == EXEC && last_byte) begin
            ovf_d = (a_byte[BYTE_W-1] == (b_byte[BYTE_W-1] ^ sub_q)) &&
                    (s_byte[BYTE_W-1] != a_byte[BYTE_W-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign rsp_ovf = ovf_q;
`else
    assign rsp_ovf = 1'b0;
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state_q == DONE);
    assign rsp_id     = id_q;
    assign rsp_sum    = sum_q;
    assign rsp_cout   = carry_q;
    assign busy       = (state_q != IDLE);

endmodule
